// File: rtl/bram_port_arbiter.sv
// Three-requester round-robin arbiter in front of a single BRAM port (IDLE/ACCESS/RESP).
// Define BRAM_ARB_VIDEO_PRIO_EN to give the video requester (index 1) absolute priority.
module bram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [2:0]            req_i,
    input  logic [2:0]            we_i,
    input  logic [3*ADDR_W-1:0]   addr_i,
    input  logic [3*DATA_W-1:0]   wdata_i,
    output logic [2:0]            ack_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [ADDR_W-1:0]     bram_addr_o,
    output logic [DATA_W-1:0]     bram_wdata_o,
    output logic                  bram_we_o,
    input  logic [DATA_W-1:0]     bram_q_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          win_q, win_d;
    logic [2:0]          ack_q, ack_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_wdata_q, bram_wdata_d;
    logic                bram_we_q, bram_we_d;
    logic [1:0]          grant_s;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        case (i)
            2'd0:    next_idx = 2'd1;
            2'd1:    next_idx = 2'd2;
            default: next_idx = 2'd0;
        endcase
    endfunction

    function automatic logic req_bit(input logic [2:0] r, input logic [1:0] i);
        case (i)
            2'd0:    req_bit = r[0];
            2'd1:    req_bit = r[1];
            2'd2:    req_bit = r[2];
            default: req_bit = 1'b0;
        endcase
    endfunction

    // Search ptr, ptr+1, ptr+2 (mod 3); callers guarantee at least one bit of r is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] c0, c1, c2;
        c0 = (p == 2'd3) ? 2'd0 : p;
        c1 = next_idx(c0);
        c2 = next_idx(c1);
        if (req_bit(r, c0)) begin
            rr_pick = c0;
        end else if (req_bit(r, c1)) begin
            rr_pick = c1;
        end else begin
            rr_pick = c2;
        end
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        case (i)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] addr_sel(input logic [3*ADDR_W-1:0] a, input logic [1:0] i);
        case (i)
            2'd1:    addr_sel = a[ADDR_W +: ADDR_W];
            2'd2:    addr_sel = a[2*ADDR_W +: ADDR_W];
            default: addr_sel = a[0 +: ADDR_W];
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] data_sel(input logic [3*DATA_W-1:0] d, input logic [1:0] i);
        case (i)
            2'd1:    data_sel = d[DATA_W +: DATA_W];
            2'd2:    data_sel = d[2*DATA_W +: DATA_W];
            default: data_sel = d[0 +: DATA_W];
        endcase
    endfunction

    // Next-state, arbitration and BRAM port register loading.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        ack_d        = 3'b000;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        bram_we_d    = 1'b0;
        grant_s      = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
`ifdef BRAM_ARB_VIDEO_PRIO_EN
                    // Video bypasses the pointer; CPU and GIO share it.
                    if (req_i[1]) begin
                        grant_s = 2'd1;
                    end else begin
                        grant_s = rr_pick(req_i & 3'b101, ptr_q);
                        ptr_d   = next_idx(grant_s);
                    end
`else
                    grant_s = rr_pick(req_i, ptr_q);
                    ptr_d   = next_idx(grant_s);
`endif
                    win_d        = grant_s;
                    state_d      = ST_ACCESS;
                    bram_addr_d  = addr_sel(addr_i, grant_s);
                    bram_wdata_d = data_sel(wdata_i, grant_s);
                    bram_we_d    = req_bit(we_i, grant_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                ack_d   = onehot(win_q);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 2'd0;
            win_q        <= 2'd0;
            ack_q        <= 3'b000;
            bram_addr_q  <= {ADDR_W{1'b0}};
            bram_wdata_q <= {DATA_W{1'b0}};
            bram_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            ack_q        <= ack_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            bram_we_q    <= bram_we_d;
        end
    end

    // BRAM read data arrives one cycle after ACCESS, i.e. exactly in RESP.
    assign rdata_o      = (state_q == ST_RESP) ? bram_q_i : {DATA_W{1'b0}};
    assign ack_o        = ack_q;
    assign bram_addr_o  = bram_addr_q;
    assign bram_wdata_o = bram_wdata_q;
    assign bram_we_o    = bram_we_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter with a transaction-level reference model and a BRAM model.
module tb_bram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        req, we;
    logic [3*AW-1:0]   addr;
    logic [3*DW-1:0]   wdata;
    logic [2:0]        ack;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_wdata;
    logic              bram_we;
    logic [DW-1:0]     bram_q;
    logic              busy;
    logic              mem_init;

    logic [DW-1:0]     bram_mem [0:(1<<AW)-1];
    logic [DW-1:0]     shadow   [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (transaction phases, not RTL encoding)
    int              m_phase;
    int              m_ptr;
    int              m_win;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    int              wait_cnt [3];
    bit              saturate;
    int              cyc;
    int              ack_log[$];
    int              ack_time[$];

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .ack_o        (ack),
        .rdata_o      (rdata),
        .bram_addr_o  (bram_addr),
        .bram_wdata_o (bram_wdata),
        .bram_we_o    (bram_we),
        .bram_q_i     (bram_q),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 5) return 16'hBEEF;
        return DW'(a * 291) ^ 16'h5A5A;
    endfunction

    // BRAM port B: registered read, write on the clock edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < (1 << AW); a++) bram_mem[a] <= init_word(a);
        end else begin
            if (bram_we) bram_mem[bram_addr] <= bram_wdata;
            bram_q <= bram_mem[bram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_win = 0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        req = 3'b000; we = 3'b000;
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    endtask

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        we[i]  = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
        wait_cnt[i] = 0;
    endtask

    task automatic new_request(input int i);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
        issue(i, 1'($urandom_range(0, 1)), a, DW'($urandom));
    endtask

    // Advance the reference model across one clock edge using the inputs held before it.
    task automatic model_advance();
        int w;
        if (m_phase == 0) begin
            if (req != 3'b000) begin
                w = -1;
`ifdef BRAM_ARB_VIDEO_PRIO_EN
                if (req[1]) begin
                    w = 1;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        int idx = (m_ptr + k) % 3;
                        if (w < 0 && idx != 1 && req[idx]) w = idx;
                    end
                    m_ptr = (w + 1) % 3;
                end
`else
                for (int k = 0; k < 3; k++) begin
                    int idx = (m_ptr + k) % 3;
                    if (w < 0 && req[idx]) w = idx;
                end
                m_ptr = (w + 1) % 3;
`endif
                m_win   = w;
                m_we    = we[w];
                m_addr  = addr[w*AW +: AW];
                m_wdata = wdata[w*DW +: DW];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_rdata = shadow[m_addr];
            if (m_we) shadow[m_addr] = m_wdata;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        logic [2:0] exp_ack;
        exp_ack = (m_phase == 2) ? (3'b001 << m_win) : 3'b000;
        check_eq("busy", busy, (m_phase != 0));
        check_eq("ack", ack, exp_ack);
        check_eq("bram_we", bram_we, (m_phase == 1) && m_we);
        check_eq("bram_addr", bram_addr, m_addr);
        check_eq("bram_wdata", bram_wdata, m_wdata);
        if (m_phase == 2 && !m_we) check_eq("rdata", rdata, m_rdata);
    endtask

    task automatic tick(input bit gen);
        @(posedge clk);
        #1;
        model_advance();
        check_outputs();
        for (int i = 0; i < 3; i++) begin
            if (m_phase == 2 && m_win == i) begin
`ifndef BRAM_ARB_VIDEO_PRIO_EN
                check_eq("grant_wait", (wait_cnt[i] <= 9), 1);
`endif
                ack_log.push_back(i);
                ack_time.push_back(cyc);
                req[i] = 1'b0;
                if (saturate) new_request(i);
            end else if (req[i]) begin
                wait_cnt[i]++;
            end else if (gen && $urandom_range(0, 3) == 0) begin
                new_request(i);
            end
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        saturate = 1'b0;
        while ((req != 3'b000 || m_phase != 0) && n < 60) begin
            tick(1'b0);
            n++;
        end
        check_eq("drain_done", (req == 3'b000 && m_phase == 0), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, ack, 3'b000);
        check_eq({tag, "_rdata"}, rdata, 16'h0000);
        check_eq({tag, "_baddr"}, bram_addr, 10'h000);
        check_eq({tag, "_bwdata"}, bram_wdata, 16'h0000);
        check_eq({tag, "_bwe"}, bram_we, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] saved;
        cyc = 0;
        saturate = 1'b0;
        reset_n = 1'b0;
        mem_init = 1'b1;
        addr = '0;
        wdata = '0;
        model_reset();
        for (int a = 0; a < (1 << AW); a++) shadow[a] = init_word(a);
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        reset_n = 1'b1;

        // Single read of word 5
        issue(0, 1'b0, 10'h005, 16'h0000);
        tick(1'b0);
        check_eq("rd_baddr", bram_addr, 10'h005);
        tick(1'b0);
        check_eq("rd_ack", ack, 3'b001);
        check_eq("rd_data", rdata, 16'hBEEF);
        tick(1'b0);

        // Single write from GIO, then CPU read-back
        issue(2, 1'b1, 10'h3FF, 16'h1234);
        tick(1'b0);
        check_eq("wr_we_on", bram_we, 1'b1);
        tick(1'b0);
        check_eq("wr_ack", ack, 3'b100);
        check_eq("wr_we_off", bram_we, 1'b0);
        tick(1'b0);
        issue(0, 1'b0, 10'h3FF, 16'h0000);
        tick(1'b0);
        tick(1'b0);
        check_eq("rb_ack", ack, 3'b001);
        check_eq("rb_data", rdata, 16'h1234);
        drain();

        // Saturated arbitration order from a fresh pointer
        pulse_reset();
        ack_log.delete();
        ack_time.delete();
        saturate = 1'b1;
        for (int i = 0; i < 3; i++) issue(i, 1'b0, AW'(i + 1), 16'h0000);
        for (int t = 0; t < 12; t++) tick(1'b0);
        check_eq("order_count", (ack_log.size() >= 4), 1);
        if (ack_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
`ifdef BRAM_ARB_VIDEO_PRIO_EN
                check_eq("order", ack_log[k], 1);
`else
                check_eq("order", ack_log[k], k % 3);
`endif
                if (k > 0) check_eq("order_gap", ack_time[k] - ack_time[k-1], 3);
            end
        end
        drain();

        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            if (t % 200 == 0) saturate = 1'($urandom_range(0, 1));
            tick(1'b1);
        end
        drain();

        // Reset during the ACCESS cycle of a write
        saved = shadow[7];
        issue(0, 1'b1, 10'h007, ~saved);
        tick(1'b0);
        check_eq("abort_we_on", bram_we, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("abort_hold");
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < 4; t++) tick(1'b0);
        check_eq("abort_mem", bram_mem[7], saved);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, BRAM word-address width.
REQ-002 Parameter DATA_W, default 16, BRAM data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req  input  3  per-requester request; bit 0 = CPU, bit 1 = video, bit 2 = GIO poller.
REQ-006 we  input  3  per-requester write enable; 1 = write, 0 = read.
REQ-007 addr  input  3*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-008 wdata  input  3*DATA_W  packed write data; requester i uses slice [i*DATA_W +: DATA_W].
REQ-009 ack  output  3  one-hot, one-cycle completion pulse per requester.
REQ-010 rdata  output  DATA_W  read data shared by all requesters; valid only in the ack cycle.
REQ-011 bram_addr  output  ADDR_W  BRAM port-B address, registered.
REQ-012 bram_wdata  output  DATA_W  BRAM port-B write data, registered.
REQ-013 bram_we  output  1  BRAM port-B write enable, registered.
REQ-014 bram_q  input  DATA_W  BRAM port-B read data; 1-cycle registered latency after address.
REQ-015 busy  output  1  high while a transaction occupies the port (ACCESS or RESP).

Function
REQ-016 Requester protocol: hold req[i], we[i], addr and wdata slices stable from assertion until ack[i] is seen.
REQ-017 FSM states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS when any req bit is high.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-018 In IDLE with requests pending, the arbiter picks the winner and registers that winner's addr, wdata and we onto bram_addr, bram_wdata and bram_we on the same edge it enters ACCESS.
REQ-019 bram_we is high for exactly the one ACCESS cycle of a write, and 0 in every other cycle.
REQ-020 In RESP, ack[winner] = 1 and rdata = bram_q; for writes rdata is also driven from bram_q and has no defined meaning.
REQ-021 Latency from req sampled in IDLE to ack is 2 cycles; maximum throughput is one transaction per 3 cycles.
REQ-022 Arbitration is round-robin via a 2-bit pointer.
- The pointer holds the highest-priority index; search order is ptr, ptr+1, ptr+2 (mod 3).
- After a grant to i, ptr = (i+1) mod 3.
REQ-023 A requester that loses arbitration waits no more than 2 transactions (6 cycles) before its grant.
REQ-024 If req[winner] drops during ACCESS or RESP (protocol violation), the transaction still completes and ack still pulses.
REQ-025 New request edges arriving in ACCESS or RESP are not sampled until the next IDLE.
REQ-026 bram_addr, bram_wdata and bram_we keep their last values outside ACCESS, except that bram_we returns to 0.
REQ-027 ack has at most one bit set in any cycle.

Reset
REQ-028 With reset = 0: state = IDLE, ptr = 0, ack = 0, rdata = 0, bram_addr = 0, bram_wdata = 0, bram_we = 0, busy = 0, all applied immediately without waiting for a clock edge.
REQ-029 Reset asserted during ACCESS or RESP aborts the transaction; no ack is issued for it, and any write not yet clocked into the BRAM is lost.

Configuration
REQ-030 Macro BRAM_ARB_VIDEO_PRIO_EN:
- Defined: the video requester (req[1]) wins whenever it requests in IDLE. The remaining requesters (CPU, GIO) round-robin between themselves, and ptr is updated only on non-video grants.
- Undefined: pure 3-way round-robin per REQ-022, and REQ-023 holds.

Verification
REQ-031 Single read: after reset, req = 001, addr0 = 0x005, BRAM word 5 = 0xBEEF -> bram_addr = 0x005 in cycle 1; ack = 001 and rdata = 0xBEEF in cycle 2.
REQ-032 Single write: req = 100, we = 100, addr2 = 0x3FF, wdata2 = 0x1234 -> bram_we = 1 for exactly 1 cycle; ack = 100; a following CPU read of 0x3FF returns 0x1234.
REQ-033 Round-robin, macro undefined: req = 111 held with re-assertion after each ack -> ack order 001, 010, 100, 001, with 3 cycles between acks.
REQ-034 Video priority, macro defined: req = 111 with video re-requesting after each ack -> every grant goes to video. Then drop video -> CPU and GIO alternate.
REQ-035 Reset mid-transaction: assert reset in the ACCESS cycle of a write -> outputs go to reset values immediately, no ack is issued, and BRAM contents are unchanged.
